prep5_dot_seq: RTL and testbench
================================

Name: prep5_dot_seq

Overview:
Upstream sequencer for the 4x4 multiply-accumulate stage (8-bit Q, registered; MAC=0 loads the product, MAC=1 adds it to Q).
- Buffers incoming operand pairs in a small FIFO.
- Issues one dot product of LEN terms onto A/B/MAC, with MAC=0 on the first term.
- Samples the accumulator's Q once the last term has landed and returns it on a valid/ready result port.
- Drives bubble terms (A=B=0, MAC=1) whenever it has nothing to issue, so Q is held.

Parameters:
- OPW, 4, operand width (must match the MAC stage's A/B width).
- ACCW, 8, accumulator width (must match the MAC stage's Q width).
- LENW, 4, width of the term-count field; max LEN = 2^LENW-1.
- FDEPTH, 4, operand FIFO depth (power of 2).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous active-high reset.
- START  in  1  begin a dot product; sampled only in IDLE.
- LEN  in  LENW  number of terms; latched with START.
- IN_VALID  in  1  operand pair valid.
- IN_A  in  OPW  operand A.
- IN_B  in  OPW  operand B.
- IN_READY  out  1  FIFO can accept.
- A  out  OPW  registered operand to the MAC stage.
- B  out  OPW  registered operand to the MAC stage.
- MAC  out  1  registered accumulate select to the MAC stage.
- Q_IN  in  ACCW  accumulator value fed back from the MAC stage.
- RES_VALID  out  1  result available.
- RES_DATA  out  ACCW  dot-product result.
- RES_READY  in  1  consumer accepts result.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, one edge):
  - A=0, B=0, MAC=0, so the MAC stage clears Q on the next edge.
  - RES_VALID=0, RES_DATA=0, BUSY=0, FIFO emptied, term counter=0, state=IDLE.
  - IN_READY=0 while RST is high.
  - RST mid-operation aborts the current product; any partial result is discarded.
- FIFO:
  - Push when IN_VALID && IN_READY, in any state, so operands may be preloaded in IDLE.
  - IN_READY = !full.
  - Push and pop in the same cycle are both allowed when not full.
  - Order is preserved; no push occurs when full.
- IDLE:
  - A/B/MAC = 0/0/1 (hold).
  - START=1 latches LEN into the remaining-count register and sets the first-term flag. Next state is RUN, or CLR if LEN=0.
- RUN, each cycle:
  - FIFO not empty: pop. At the edge, A/B <= head; MAC <= !first; first <= 0; remaining decrements.
  - FIFO empty: A/B <= 0, MAC <= 1 (bubble); Q unaffected; remaining unchanged.
  - When the pop that takes remaining to 0 occurs, next state is FLUSH.
- CLR (LEN=0 only): A/B <= 0, MAC <= 0 for one cycle, then FLUSH. Result is 0.
- FLUSH:
  - Two cycles with A/B/MAC <= 0/0/1.
  - At the edge ending the second FLUSH cycle: RES_DATA <= Q_IN, RES_VALID <= 1, state=DONE.
  - Timing: the last term is on A/B in cycle n; Q_IN is final in cycle n+1; RES_VALID is high from cycle n+2.
- DONE:
  - A/B/MAC hold 0/0/1.
  - RES_VALID and RES_DATA are held stable until RES_READY=1, then RES_VALID <= 0 and state=IDLE.
  - START in RUN, CLR, FLUSH or DONE is ignored (not queued).
- Arithmetic:
  - Each product is OPW x OPW -> 2*OPW bits, zero-extended to ACCW.
  - Accumulation wraps modulo 2^ACCW. There is no saturation and no overflow flag.
  - The result is exactly the MAC stage's Q.

Decomposition:
- Shared package prep_pkg holds:
  - constants OPW=4, ACCW=8, LENW=4;
  - state enum {IDLE, RUN, CLR, FLUSH, DONE};
  - idle-drive constant {A=0, B=0, MAC=1}.
- One sub-module, prep5_op_fifo: synchronous FIFO, width 2*OPW, depth FDEPTH, with full/empty flags, push/pop ports and a synchronous reset.
- Testbench instantiates prep5_dot_seq driving the MAC stage, with Q fed back.

Test Plan:
- Preload pairs (3,4),(5,6),(15,15) in IDLE; START with LEN=3 -> MAC sequence 0,1,1 on consecutive cycles; RES_DATA=12+30+225=267 mod 256=11; RES_VALID exactly 2 cycles after the last term.
- LEN=2 with the FIFO empty at START; push (2,2) then, after 3 idle cycles, (1,7) -> bubbles hold Q at 4; RES_DATA=11.
- LEN=0 with START -> one A=B=0, MAC=0 cycle; RES_DATA=0; the FIFO contents are not popped.
- Hold RES_READY=0 for 5 cycles in DONE while pulsing START -> RES_VALID and RES_DATA stable, START ignored; after RES_READY=1, IDLE and the next START is accepted.
- Push 6 pairs back-to-back with no START -> IN_READY drops after 4 pushes, and a push attempted while full does not corrupt the FIFO; START LEN=4 -> pops in order; IN_READY re-asserts after the first pop.
- Assert RST during RUN after 2 of 4 terms -> the next cycle shows A=B=0, MAC=0, FIFO empty, RES_VALID=0, BUSY=0; a fresh product then runs correctly.

Source files
------------

// File: rtl/prep_pkg.sv
// Shared definitions for the prep5 dot-product sequencer.
//   OPW/ACCW/LENW : default operand, accumulator and term-count widths
//   state_t       : sequencer FSM states
//   drive_t       : one term as presented to the MAC stage
//   IDLE_DRIVE    : bubble term {A=0, B=0, MAC=1}; it adds zero, so Q is held
package prep_pkg;

    localparam int OPW  = 4;
    localparam int ACCW = 8;
    localparam int LENW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        CLR   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           mac;
    } drive_t;

    localparam drive_t IDLE_DRIVE = '{a: '0, b: '0, mac: 1'b1};

endpackage

// File: rtl/prep5_op_fifo.sv
// Synchronous operand-pair FIFO.
//   CLK, RST : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write a word; ignored when full
//   pop/dout : dout is the current head (show-ahead); pop advances it,
//              ignored when empty
//   full, empty : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module prep5_op_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/prep5_dot_seq.sv
// Dot-product sequencer in front of a registered 4x4 multiply-accumulate
// stage (MAC=0 loads A*B into Q, MAC=1 adds A*B to Q).
//   CLK, RST               : clock, synchronous active-high reset
//   START, LEN             : begin a LEN-term product (sampled in IDLE only)
//   IN_VALID/IN_READY,
//   IN_A, IN_B             : operand-pair push into the FIFO (any state)
//   A, B, MAC              : registered term driven to the MAC stage
//   Q_IN                   : accumulator fed back from the MAC stage
//   RES_VALID/RES_READY,
//   RES_DATA               : result handshake
//   BUSY                   : state != IDLE
module prep5_dot_seq
    import prep_pkg::*;
#(
    parameter int OPW    = prep_pkg::OPW,
    parameter int ACCW   = prep_pkg::ACCW,
    parameter int LENW   = prep_pkg::LENW,
    parameter int FDEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [LENW-1:0] LEN,
    input  logic            IN_VALID,
    input  logic [OPW-1:0]  IN_A,
    input  logic [OPW-1:0]  IN_B,
    output logic            IN_READY,
    output logic [OPW-1:0]  A,
    output logic [OPW-1:0]  B,
    output logic            MAC,
    input  logic [ACCW-1:0] Q_IN,
    output logic            RES_VALID,
    output logic [ACCW-1:0] RES_DATA,
    input  logic            RES_READY,
    output logic            BUSY
);

    state_t          state;
    logic [LENW-1:0] rem;
    logic            first;
    logic            flush_second;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [2*OPW-1:0] head;

    // Holding IN_READY low during reset keeps pushes out of a FIFO that is
    // being cleared on the same edge.
    assign IN_READY  = !fifo_full && !RST;
    assign fifo_push = IN_VALID && IN_READY;
    assign fifo_pop  = (state == RUN) && !fifo_empty;
    assign BUSY      = (state != IDLE);

    prep5_op_fifo #(
        .W     (2*OPW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .din   ({IN_A, IN_B}),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            // MAC=0 with zero operands clears Q on the following edge.
            state        <= IDLE;
            rem          <= '0;
            first        <= 1'b0;
            flush_second <= 1'b0;
            A            <= '0;
            B            <= '0;
            MAC          <= 1'b0;
            RES_VALID    <= 1'b0;
            RES_DATA     <= '0;
        end else begin
            // Default term is a bubble; states below override it.
            A   <= '0;
            B   <= '0;
            MAC <= IDLE_DRIVE.mac;

            case (state)
                IDLE: begin
                    if (START) begin
                        rem   <= LEN;
                        first <= 1'b1;
                        state <= (LEN == '0) ? CLR : RUN;
                    end
                end

                RUN: begin
                    // An empty FIFO leaves the bubble in place and the
                    // count untouched, so the product simply stretches.
                    if (!fifo_empty) begin
                        A     <= head[2*OPW-1:OPW];
                        B     <= head[OPW-1:0];
                        MAC   <= !first;
                        first <= 1'b0;
                        rem   <= rem - LENW'(1);
                        if (rem == LENW'(1)) begin
                            state        <= FLUSH;
                            flush_second <= 1'b0;
                        end
                    end
                end

                CLR: begin
                    // Zero-length product: load 0*0 so Q reads back 0.
                    MAC          <= 1'b0;
                    state        <= FLUSH;
                    flush_second <= 1'b0;
                end

                FLUSH: begin
                    // First cycle: last term is on A/B. Second cycle: Q_IN
                    // holds the final sum.
                    flush_second <= 1'b1;
                    if (flush_second) begin
                        RES_DATA  <= Q_IN;
                        RES_VALID <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prep5_dot_seq.sv
module tb_prep5_dot_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] LEN;
    logic       IN_VALID;
    logic [3:0] IN_A;
    logic [3:0] IN_B;
    logic       IN_READY;
    logic [3:0] A;
    logic [3:0] B;
    logic       MAC;
    logic [7:0] Q_IN;
    logic       RES_VALID;
    logic [7:0] RES_DATA;
    logic       RES_READY;
    logic       BUSY;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    prep5_dot_seq #(.FDEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .LEN       (LEN),
        .IN_VALID  (IN_VALID),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .MAC       (MAC),
        .Q_IN      (Q_IN),
        .RES_VALID (RES_VALID),
        .RES_DATA  (RES_DATA),
        .RES_READY (RES_READY),
        .BUSY      (BUSY)
    );

    // Behavioural MAC stage, fed back into the sequencer.
    logic [7:0] q_mac = '0;
    logic [7:0] prod;
    assign prod = {4'h0, A} * {4'h0, B};
    always @(posedge CLK) begin
        if (!MAC) q_mac <= prod;
        else      q_mac <= q_mac + prod;
    end
    assign Q_IN = q_mac;

    typedef struct {
        int         len;
        logic [3:0] a [4];
        logic [3:0] b [4];
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // Preload the FIFO in IDLE, run one product, check every term, the
    // result timing, the value and the handshake back to IDLE.
    task automatic run_vec(input int id, input vec_t v);
        for (int k = 0; k < v.len; k++) begin
            IN_VALID = 1'b1; IN_A = v.a[k]; IN_B = v.b[k];
            tick();
        end
        IN_VALID = 1'b0;
        START = 1'b1; LEN = 4'(v.len);
        tick();
        START = 1'b0;
        chk($sformatf("v%0d_busy", id), BUSY, 1);
        for (int k = 0; k < v.len; k++) begin
            tick();
            chk($sformatf("v%0d_t%0d_a", id, k), A, v.a[k]);
            chk($sformatf("v%0d_t%0d_b", id, k), B, v.b[k]);
            chk($sformatf("v%0d_t%0d_mac", id, k), MAC, (k == 0) ? 0 : 1);
        end
        tick();
        chk($sformatf("v%0d_valid_early", id), RES_VALID, 0);
        tick();
        chk($sformatf("v%0d_valid", id), RES_VALID, 1);
        chk($sformatf("v%0d_data", id), RES_DATA, v.exp);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        chk($sformatf("v%0d_valid_clr", id), RES_VALID, 0);
        chk($sformatf("v%0d_idle", id), BUSY, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vr;
        logic [3:0] fa [6];
        logic [3:0] fb [6];

        vecs[0] = '{3, '{4'd3, 4'd5, 4'd15, 4'd0}, '{4'd4, 4'd6, 4'd15, 4'd0}, 8'd11};
        vecs[1] = '{1, '{4'd7, 4'd0, 4'd0, 4'd0}, '{4'd9, 4'd0, 4'd0, 4'd0}, 8'd63};
        vecs[2] = '{4, '{4'd15, 4'd15, 4'd15, 4'd15}, '{4'd15, 4'd15, 4'd15, 4'd15}, 8'd132};
        vecs[3] = '{2, '{4'd0, 4'd2, 4'd0, 4'd0}, '{4'd5, 4'd3, 4'd0, 4'd0}, 8'd6};
        vecs[4] = '{4, '{4'd1, 4'd2, 4'd3, 4'd4}, '{4'd1, 4'd2, 4'd3, 4'd4}, 8'd30};

        RST = 1'b1; START = 1'b0; LEN = '0; IN_VALID = 1'b0;
        IN_A = '0; IN_B = '0; RES_READY = 1'b0;
        tick(); tick();
        chk("rst_a", A, 0);
        chk("rst_b", B, 0);
        chk("rst_mac", MAC, 0);
        chk("rst_valid", RES_VALID, 0);
        chk("rst_data", RES_DATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", IN_READY, 0);
        RST = 1'b0;
        tick();
        chk("idle_mac", MAC, 1);
        chk("idle_ready", IN_READY, 1);

        for (int i = 0; i < 5; i++)
            run_vec(i, vecs[i]);

        // LEN=2 started on an empty FIFO; operands trickle in with gaps.
        START = 1'b1; LEN = 4'd2;
        tick();
        START = 1'b0;
        IN_VALID = 1'b1; IN_A = 4'd2; IN_B = 4'd2;
        tick();
        IN_VALID = 1'b0;
        chk("gap_bubble0_mac", MAC, 1);
        tick();
        chk("gap_t0_a", A, 2);
        chk("gap_t0_mac", MAC, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("gap_bubble%0d_mac", k + 1), MAC, 1);
            chk($sformatf("gap_bubble%0d_a", k + 1), A, 0);
            chk($sformatf("gap_bubble%0d_busy", k + 1), BUSY, 1);
        end
        IN_VALID = 1'b1; IN_A = 4'd1; IN_B = 4'd7;
        tick();
        IN_VALID = 1'b0;
        tick();
        chk("gap_t1_a", A, 1);
        chk("gap_t1_b", B, 7);
        chk("gap_t1_mac", MAC, 1);
        tick();
        chk("gap_valid_early", RES_VALID, 0);
        tick();
        chk("gap_valid", RES_VALID, 1);
        chk("gap_data", RES_DATA, 11);

        // Stall in DONE with START toggling; nothing may move.
        for (int k = 0; k < 5; k++) begin
            START = (k % 2 == 0);
            LEN = 4'd1;
            tick();
            chk($sformatf("stall%0d_valid", k), RES_VALID, 1);
            chk($sformatf("stall%0d_data", k), RES_DATA, 11);
            chk($sformatf("stall%0d_busy", k), BUSY, 1);
        end
        START = 1'b0; RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        chk("stall_release_valid", RES_VALID, 0);
        chk("stall_release_idle", BUSY, 0);

        // LEN=0 with one pair waiting; the pair must survive.
        IN_VALID = 1'b1; IN_A = 4'd9; IN_B = 4'd9;
        tick();
        IN_VALID = 1'b0;
        START = 1'b1; LEN = 4'd0;
        tick();
        START = 1'b0;
        chk("len0_busy", BUSY, 1);
        tick();
        chk("len0_clr_mac", MAC, 0);
        chk("len0_clr_a", A, 0);
        chk("len0_clr_b", B, 0);
        tick();
        chk("len0_flush_mac", MAC, 1);
        chk("len0_valid_early", RES_VALID, 0);
        tick();
        chk("len0_valid", RES_VALID, 1);
        chk("len0_data", RES_DATA, 0);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        START = 1'b1; LEN = 4'd1;
        tick();
        START = 1'b0;
        tick();
        chk("len0_kept_a", A, 9);
        chk("len0_kept_mac", MAC, 0);
        tick(); tick();
        chk("len0_kept_data", RES_DATA, 81);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;

        // Overfill: 6 back-to-back pushes, only 4 land.
        for (int k = 0; k < 6; k++) begin
            fa[k] = 4'(2 * k + 1);
            fb[k] = 4'(2 * k + 2);
        end
        for (int k = 0; k < 6; k++) begin
            IN_VALID = 1'b1; IN_A = fa[k]; IN_B = fb[k];
            #1;
            chk($sformatf("fill%0d_ready", k), IN_READY, (k < 4) ? 1 : 0);
            tick();
        end
        IN_VALID = 1'b0;
        START = 1'b1; LEN = 4'd4;
        tick();
        START = 1'b0;
        chk("fill_full_ready", IN_READY, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) chk("fill_ready_back", IN_READY, 1);
            chk($sformatf("fill_t%0d_a", k), A, fa[k]);
            chk($sformatf("fill_t%0d_b", k), B, fb[k]);
        end
        tick(); tick();
        chk("fill_valid", RES_VALID, 1);
        chk("fill_data", RES_DATA, 100);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;

        // Reset after 2 of 4 terms, then a clean product.
        for (int k = 0; k < 4; k++) begin
            IN_VALID = 1'b1; IN_A = 4'(2 * k + 2); IN_B = 4'(2 * k + 3);
            tick();
        end
        IN_VALID = 1'b0;
        START = 1'b1; LEN = 4'd4;
        tick();
        START = 1'b0;
        tick(); tick();
        chk("abort_mid_a", A, 4);
        RST = 1'b1;
        tick();
        chk("abort_a", A, 0);
        chk("abort_b", B, 0);
        chk("abort_mac", MAC, 0);
        chk("abort_valid", RES_VALID, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_ready", IN_READY, 0);
        RST = 1'b0;
        tick();
        chk("abort_ready_back", IN_READY, 1);
        vr = '{2, '{4'd3, 4'd2, 4'd0, 4'd0}, '{4'd3, 4'd5, 4'd0, 4'd0}, 8'd19};
        run_vec(9, vr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
